// File: rtl/spi_image_loader_if.sv
// Pin bundle of spi_image_loader: SPI host pins plus the recognition-core side.
// slave = the loader's view, master = host/core view.
interface spi_image_loader_if;
  logic       SCK;
  logic       SS;
  logic       MOSI;
  logic       MISO;
  logic [7:0] pixel_rd_addr;
  logic [3:0] pixel_data;
  logic       image_ready;
  logic       image_ack;
  logic [3:0] result;
  logic       result_strobe;

  modport slave (
    input  SCK, SS, MOSI, pixel_rd_addr, image_ack, result, result_strobe,
    output MISO, pixel_data, image_ready
  );

  modport master (
    output SCK, SS, MOSI, pixel_rd_addr, image_ack, result, result_strobe,
    input  MISO, pixel_data, image_ready
  );
endinterface

// File: rtl/spi_image_loader.sv
// SPI slave that unpacks nibble-packed bytes into a 4-bit pixel buffer and returns a status byte.
// Optional trailing checksum byte after the image: `define IMG_CHECKSUM_EN.
module spi_image_loader #(
  parameter int unsigned IMG_PIXELS = 144
) (
  input  logic              clk,
  input  logic              n_rst,
  spi_image_loader_if.slave bus
);
  localparam int unsigned IMG_BYTES = IMG_PIXELS / 2;
  localparam logic [6:0]  LAST_BYTE = 7'(IMG_BYTES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  logic [2:0] sck_s_q, sck_s_d;
  logic [2:0] ss_s_q, ss_s_d;
  logic [1:0] mosi_s_q, mosi_s_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       miso_en_q, miso_en_d;
  logic [1:0] state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       rv_q, rv_d;
  logic [3:0] res_q, res_d;
  logic [3:0] pix_q [IMG_PIXELS];
  logic [3:0] pix_d [IMG_PIXELS];
`ifdef IMG_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif

  logic       sck_rise, ss_fall, ss_rise, ss_low, byte_done;
  logic [7:0] rx_byte, status, widx;
  logic [1:0] st;

  assign sck_rise = sck_s_q[1] & ~sck_s_q[2];
  assign ss_fall  = ~ss_s_q[1] & ss_s_q[2];
  assign ss_rise  = ss_s_q[1] & ~ss_s_q[2];
  assign ss_low   = ~ss_s_q[1];
  assign rx_byte  = {mosi_s_q[1], rx_q};
  assign widx     = {cnt_q, 1'b0};
  assign status   = {(state_q == ST_LOAD), err_q, (state_q == ST_FULL), rv_q, res_q};

  assign bus.MISO        = miso_en_q & tx_q[0];
  assign bus.image_ready = (state_q == ST_FULL);
  assign bus.pixel_data  = (32'(bus.pixel_rd_addr) < IMG_PIXELS) ? pix_q[bus.pixel_rd_addr] : '0;

  always_comb begin
    sck_s_d   = {sck_s_q[1:0], bus.SCK};
    ss_s_d    = {ss_s_q[1:0], bus.SS};
    mosi_s_d  = {mosi_s_q[0], bus.MOSI};
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_en_d = miso_en_q;
    byte_done = 1'b0;

    if (ss_rise) begin
      bit_cnt_d = '0;
      miso_en_d = 1'b0;
    end else if (sck_rise && ss_low) begin
      rx_d = rx_byte[7:1];
      tx_d = {1'b0, tx_q[7:1]};
      if (bit_cnt_q == 3'd7) begin
        byte_done = 1'b1;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end
    if (ss_fall) begin
      tx_d      = status;
      bit_cnt_d = '0;
      miso_en_d = 1'b1;
    end
  end

  always_comb begin
    pix_d = pix_q;
    cnt_d = cnt_q;
    err_d = err_q;
    rv_d  = rv_q;
    res_d = res_q;
`ifdef IMG_CHECKSUM_EN
    sum_d = sum_q;
`endif
    // an ack lands before a same-cycle byte, so a load command right after release is accepted
    st = (bus.image_ack && state_q == ST_FULL) ? ST_IDLE : state_q;
    state_d = st;

    if (byte_done) begin
      case (st)
        ST_IDLE, ST_FULL: begin
          if (rx_byte == 8'h00) begin
            if (st == ST_FULL) begin
              err_d = 1'b1;
            end else begin
              state_d = ST_LOAD;
              cnt_d   = '0;
              err_d   = 1'b0;
`ifdef IMG_CHECKSUM_EN
              sum_d   = '0;
`endif
            end
          end else if (rx_byte == 8'hFF) begin
            rv_d = 1'b0;
          end
        end
        ST_LOAD: begin
          pix_d[widx]        = rx_byte[3:0];
          pix_d[widx + 8'd1] = rx_byte[7:4];
          cnt_d = cnt_q + 7'd1;
`ifdef IMG_CHECKSUM_EN
          sum_d = sum_q + rx_byte;
          if (cnt_q == LAST_BYTE) state_d = ST_CHECK;
`else
          if (cnt_q == LAST_BYTE) state_d = ST_FULL;
`endif
        end
`ifdef IMG_CHECKSUM_EN
        ST_CHECK: begin
          if (rx_byte == sum_q) begin
            state_d = ST_FULL;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end

    if (bus.result_strobe) begin
      res_d = bus.result;
      rv_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sck_s_q   <= '0;
      ss_s_q    <= '1;
      mosi_s_q  <= '0;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      miso_en_q <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      rv_q      <= 1'b0;
      res_q     <= '0;
`ifdef IMG_CHECKSUM_EN
      sum_q     <= '0;
`endif
      for (int unsigned i = 0; i < IMG_PIXELS; i++) pix_q[i] <= '0;
    end else begin
      sck_s_q   <= sck_s_d;
      ss_s_q    <= ss_s_d;
      mosi_s_q  <= mosi_s_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      miso_en_q <= miso_en_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rv_q      <= rv_d;
      res_q     <= res_d;
`ifdef IMG_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
      pix_q     <= pix_d;
    end
  end
endmodule

// File: tb/tb_spi_image_loader.sv
// Scoreboard bench for spi_image_loader: a transaction-level model predicts status bytes,
// image_ready, MISO and pixel reads; monitors pop and compare as the DUT presents them.
module tb_spi_image_loader;
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  spi_image_loader_if bus();
  spi_image_loader #(.IMG_PIXELS(144)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  typedef struct {
    int         kind;   // 0 pixel_data, 1 image_ready, 2 MISO
    logic [7:0] exp;
    string      name;
  } chk_t;

  chk_t       out_q[$];
  logic [7:0] stat_q[$];
  int         errors = 0;
  int         checks = 0;
  logic       chk_req = 1'b0;
  logic [7:0] mbits = '0;
  int         mcnt = 0;

  // behavioural model of the loader, byte-transaction level
  logic [3:0] m_img [144];
  logic       m_ready, m_load, m_chk, m_err, m_rv;
  logic [3:0] m_res;
  int         m_cnt;
  logic [7:0] m_sum;

  function automatic logic [7:0] m_status();
    return {m_load, m_err, m_ready, m_rv, m_res};
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 144; i++) m_img[i] = '0;
    m_ready = 0; m_load = 0; m_chk = 0; m_err = 0; m_rv = 0;
    m_res = '0; m_cnt = 0; m_sum = '0;
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    if (m_load) begin
      m_img[2*m_cnt]   = b[3:0];
      m_img[2*m_cnt+1] = b[7:4];
      m_sum = m_sum + b;
      m_cnt++;
      if (m_cnt == 72) begin
        m_load = 0;
`ifdef IMG_CHECKSUM_EN
        m_chk = 1;
`else
        m_ready = 1;
`endif
      end
    end else if (m_chk) begin
      m_chk = 0;
      if (b == m_sum) m_ready = 1;
      else m_err = 1;
    end else if (b == 8'h00) begin
      if (m_ready) m_err = 1;
      else begin m_load = 1; m_cnt = 0; m_err = 0; m_sum = '0; end
    end else if (b == 8'hFF) begin
      m_rv = 0;
    end
  endfunction

  // status byte monitor: collects MISO at each SCK rise, compares when a full frame ends
  always @(posedge bus.SCK) begin
    if (bus.SS === 1'b0 && mcnt < 8) begin
      mbits[mcnt[2:0]] = bus.MISO;
      mcnt++;
    end
  end

  always @(posedge bus.SS) begin
    if (mcnt == 8) begin
      checks++;
      if (stat_q.size() == 0) begin
        errors++;
        $display("FAIL status: got %02h but nothing was expected", mbits);
      end else begin
        logic [7:0] e;
        e = stat_q.pop_front();
        if (mbits !== e) begin
          errors++;
          $display("FAIL status: got %02h expected %02h", mbits, e);
        end
      end
    end
    mcnt = 0;
  end

  // output monitor for pixel_data / image_ready / MISO requests
  always @(posedge clk) begin
    if (chk_req) begin
      #1;
      checks++;
      if (out_q.size() == 0) begin
        errors++;
        $display("FAIL outq: output check with empty queue");
      end else begin
        chk_t c;
        logic [7:0] act;
        c = out_q.pop_front();
        case (c.kind)
          0:       act = {4'b0, bus.pixel_data};
          1:       act = {7'b0, bus.image_ready};
          default: act = {7'b0, bus.MISO};
        endcase
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h (addr %0d)", c.name, act, c.exp, bus.pixel_rd_addr);
        end
      end
    end
  end

  task automatic expect_out(input int kind, input logic [7:0] addr, input logic [7:0] exp, input string nm);
    @(negedge clk);
    bus.pixel_rd_addr = addr;
    out_q.push_back('{kind: kind, exp: exp, name: nm});
    chk_req = 1'b1;
    @(negedge clk);
    chk_req = 1'b0;
  endtask

  task automatic spi_frame(input logic [7:0] b, input int nbits);
    if (nbits == 8) stat_q.push_back(m_status());
    @(negedge clk);
    bus.SS = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      bus.MOSI = b[i];
      repeat (4) @(negedge clk);
      bus.SCK = 1'b1;
      repeat (4) @(negedge clk);
      bus.SCK = 1'b0;
    end
    repeat (4) @(negedge clk);
    bus.SS = 1'b1;
    repeat (6) @(negedge clk);
    if (nbits == 8) m_byte(b);
  endtask

  task automatic strobe(input logic [3:0] r);
    @(negedge clk);
    bus.result = r;
    bus.result_strobe = 1'b1;
    @(negedge clk);
    bus.result_strobe = 1'b0;
    m_res = r;
    m_rv  = 1;
  endtask

  task automatic ack();
    @(negedge clk);
    bus.image_ack = 1'b1;
    out_q.push_back('{kind: 1, exp: 8'h00, name: "ack_ready"});
    chk_req = 1'b1;
    @(negedge clk);
    bus.image_ack = 1'b0;
    chk_req = 1'b0;
    m_ready = 0;
  endtask

  // load command + 72 bytes (pattern or random), optional partial frame, optional sum byte
  task automatic load_image(input bit pattern, input int abort_at, input int sum_off);
    logic [7:0] b;
    spi_frame(8'h00, 8);
    for (int k = 0; k < 72; k++) begin
      if (k == abort_at) spi_frame(8'($urandom), 5);
      if (pattern) b = {4'((2*k+1) & 15), 4'((2*k) & 15)};
      else b = 8'($urandom);
      spi_frame(b, 8);
    end
`ifdef IMG_CHECKSUM_EN
    spi_frame(8'(m_sum + sum_off), 8);
`else
    if (sum_off != 0) $display("note: checksum byte not used in this build");
`endif
  endtask

  task automatic read_all(input string nm);
    for (int a = 0; a < 144; a++) expect_out(0, 8'(a), {4'b0, m_img[a]}, nm);
  endtask

  initial begin
    m_reset();
    n_rst = 1'b0;
    bus.SCK = 1'b0; bus.SS = 1'b1; bus.MOSI = 1'b0;
    bus.pixel_rd_addr = '0; bus.image_ack = 1'b0;
    bus.result = '0; bus.result_strobe = 1'b0;
    repeat (3) @(negedge clk);
    expect_out(1, 8'd0, 8'h00, "rst_ready");
    expect_out(2, 8'd0, 8'h00, "rst_miso");
    expect_out(0, 8'd5, 8'h00, "rst_pixel");
    n_rst = 1'b1;
    repeat (3) @(negedge clk);

    // pattern load and readback
    load_image(1'b1, -1, 0);
    expect_out(1, 8'd0, {7'b0, m_ready}, "load_ready");
    read_all("pattern_pixel");
    expect_out(0, 8'd200, 8'h00, "pixel_oob");
    expect_out(0, 8'd144, 8'h00, "pixel_edge");

    // result reporting
    strobe(4'd7);
    spi_frame(8'hFF, 8);
    spi_frame(8'($urandom_range(1, 254)), 8);

    // overrun: load command while full
    spi_frame(8'h00, 8);
    spi_frame(8'($urandom_range(1, 254)), 8);
    spi_frame(8'($urandom_range(1, 254)), 8);
    for (int i = 0; i < 8; i++) begin
      int a;
      a = $urandom_range(0, 143);
      expect_out(0, 8'(a), {4'b0, m_img[a]}, "overrun_pixel");
    end
    spi_frame(8'h5A, 8);
    ack();

    // random image with an aborted frame mid-load
    load_image(1'b0, 3, 0);
    expect_out(1, 8'd0, {7'b0, m_ready}, "abort_ready");
    read_all("abort_pixel");
    ack();

    // random result strobes and idle bytes
    for (int i = 0; i < 6; i++) begin
      strobe(4'($urandom));
      spi_frame(8'($urandom_range(1, 255)), 8);
    end

    // reset mid-load
    spi_frame(8'h00, 8);
    for (int i = 0; i < 30; i++) spi_frame(8'($urandom), 8);
    @(negedge clk);
    n_rst = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    expect_out(1, 8'd0, 8'h00, "midrst_ready");
    expect_out(2, 8'd0, 8'h00, "midrst_miso");
    read_all("midrst_pixel");
    spi_frame(8'hFF, 8);

`ifdef IMG_CHECKSUM_EN
    load_image(1'b0, -1, 0);
    expect_out(1, 8'd0, 8'h01, "sum_good_ready");
    ack();
    load_image(1'b0, -1, 1);
    expect_out(1, 8'd0, 8'h00, "sum_bad_ready");
    spi_frame(8'hFF, 8);
`endif

    repeat (4) @(negedge clk);
    checks++;
    if (stat_q.size() != 0 || out_q.size() != 0) begin
      errors++;
      $display("FAIL pending: status left %0d outputs left %0d required 0", stat_q.size(), out_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_image_loader.md
# spi_image_loader

SPI slave front end of the digit recognizer. It deserializes command and pixel bytes from the host, unpacks 72 packed bytes into a 144-entry 4-bit pixel buffer (12×12 image), and hands the image to the recognition core. It also returns a status/result byte on MISO during every SPI frame. It sits between the top-level SPI pins and the recognition core.

## Interface
- `IMG_PIXELS`, default 144: number of 4-bit pixels per image; must be even.
- `clk`  in  1  system clock; one clock domain.
- `n_rst`  in  1  asynchronous, active-low reset.
- `SCK`  in  1  SPI clock; asynchronous to `clk`, period at least 8 `clk` periods.
- `SS`  in  1  SPI select, active low; one byte per low pulse.
- `MOSI`  in  1  SPI data in, sent LSB first.
- `MISO`  out  1  SPI data out, sent LSB first; driven 0 while `SS` is high.
- `pixel_rd_addr`  in  8  pixel read index for the core.
- `pixel_data`  out  4  `buf[pixel_rd_addr]`, combinational; reads 0 when the index is ≥ `IMG_PIXELS`.
- `image_ready`  out  1  a complete image is held in the buffer.
- `image_ack`  in  1  single-cycle pulse from the core: image consumed, release the buffer.
- `result`  in  4  recognized digit from the core.
- `result_strobe`  in  1  single-cycle pulse: `result` is valid.

## Operation
- **Input sync:** `SCK`, `SS` and `MOSI` each pass through a 2-FF synchronizer. Rising edges of `SCK` and falling/rising edges of `SS` are detected on the synchronized signals.
- **Bit capture:** on each `SCK` rising edge with `SS` low, shift `MOSI` into `rx[7]` and shift the register right, so the first bit ends up in `rx[0]`. A bit counter runs 0..7; the byte completes on the 8th bit.
- **Aborted frame:** if `SS` rises before 8 bits, the partial byte is discarded and the bit counter is cleared. State and byte count are unchanged.
- **Status byte:** latched at the `SS` falling edge as `{loading, err, image_ready, result_valid, result_q[3:0]}`, bit0 = `result_q[0]`. Bit0 drives MISO immediately; each `SCK` rising edge advances MISO to the next bit.
- **FSM states:**
  - `IDLE`
    - Byte 0x00 → `LOAD`, byte count cleared, `err` cleared. If `image_ready` = 1, the command is ignored and `err` is set.
    - Byte 0xFF → clear `result_valid`.
    - Any other byte is ignored.
  - `LOAD`
    - Byte k (0..71) writes `buf[2k]` = byte[3:0] and `buf[2k+1]` = byte[7:4].
    - After byte 71 → `FULL` (or `CHECK` when the checksum feature is enabled).
    - `loading` = 1 throughout this state.
  - `FULL`
    - `image_ready` = 1.
    - `image_ack` → `image_ready` cleared → `IDLE`.
    - Bytes received in this state are treated as in `IDLE`. A load command here sets `err`.
- **Result register:** `result_strobe` loads `result_q` and sets `result_valid`. If `result_strobe` and a 0xFF clear land in the same cycle, the strobe wins and `result_valid` = 1.
- **Ack and command in the same cycle:** if `image_ack` and a completed 0x00 byte land in the same cycle, the ack is applied first and the load is accepted.
- **Reset:**
  - Outputs: `MISO` 0, `image_ready` 0.
  - Registers: `result_q` 0, `result_valid` 0, `err` 0, buffer all zeros, state `IDLE`, counters 0.
  - Reset mid-load discards the partial image.

## Timing
- `SCK` edge detection lags the pin by 3 `clk` cycles (2 synchronizer stages + 1 edge-detect stage).
- A byte completes on the cycle its 8th edge is detected. The buffer write and state change happen on the next `clk` edge.
- `image_ready` rises 1 `clk` cycle after the final pixel byte completes.
- `image_ready` falls on the `clk` edge after `image_ack` is sampled high.
- MISO changes about 3 `clk` cycles after each `SCK` rising edge, well before the next master sample.
- `pixel_data` has zero-cycle latency from `pixel_rd_addr`. The core reads only while `image_ready` = 1; the buffer is stable in `FULL`.

## Configuration
- `IMG_CHECKSUM_EN`
  - **Defined:** after byte 71, the FSM enters state `CHECK` and expects one more byte equal to the mod-256 sum of the 72 pixel bytes.
    - Match → `FULL`.
    - Mismatch → `IDLE`, `err` = 1, `image_ready` stays 0.
  - **Undefined:** the `CHECK` state does not exist; byte 71 goes directly to `FULL`.

## Test plan
- **Load and readback:** reset, then send 0x00 followed by 72 bytes 0x10, 0x32, …, with byte k = ((2k+1)&15)<<4 | (2k&15). Expect `image_ready` = 1 one cycle after the last byte. Expect reads at addr 0..143 to return `addr & 15`; addr 200 → 0.
- **Result reporting:** pulse `result_strobe` with `result` = 7, then send byte 0xFF. Expect MISO to return 0x37 (valid=1, ready=1) LSB first. The following frame returns 0x27.
- **Overrun:** with `image_ready` = 1, send 0x00 plus 2 bytes. Expect the buffer unchanged and the next status bit6 (`err`) = 1. Then `image_ack` → `image_ready` = 0 on the next cycle.
- **Aborted frame:** raise `SS` after 5 bits mid-`LOAD`. Expect the byte count unchanged; the following full bytes land at the correct pixel indices.
- **Reset mid-load:** assert `n_rst` after 30 bytes. Expect the FSM in `IDLE`, the buffer all 0, and MISO 0.
- **Checksum (with `IMG_CHECKSUM_EN`):** a correct sum byte → `image_ready` = 1. A sum off by 1 → `image_ready` = 0 and status bit6 = 1.
